sync_fifo: RTL and testbench

- Single-clock FIFO; the successor to the dual-clock FIFO, for intra-domain buffering in the FPGA datapath (sensor/PWM capture to AXI/register bridge).
- Adds the following over the previous generation:
  - a full-width word count;
  - programmable almost-full and almost-empty thresholds;
  - a selectable first-word-fall-through (FWFT) read mode;
  - sticky overflow/underflow error flags.
- All status outputs are registered and exact; there is no latch-based status and no clock-domain crossing.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/sync_fifo_ram.sv | 57 +++++
 rtl/sync_fifo.sv | 224 ++++++++++++++++++++++
 tb/tb_sync_fifo.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the single-clock FIFO.
//               FIFO_MODE_STD  - registered read, one-cycle read latency
//               FIFO_MODE_FWFT - first-word-fall-through read
//               fifo_count_width() - width of a word count that must be able
//               to represent the full capacity (0..2**address_width).
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int fifo_count_width(input int address_width);
        return address_width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ram
// Description : Simple dual-port RAM, DATA_WIDTH x 2**ADDRESS_WIDTH.
//               One write port, one synchronous read port with read enable.
//               Read-first: a read and a write to the same address in the
//               same cycle return the old contents. Only the read data
//               register is reset; the array itself is never cleared.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset of read data reg
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_re     - read enable
//               i_raddr  - read address
//               o_rdata  - read data (valid the cycle after i_re)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [ADDRESS_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic                     i_re,
    input  logic [ADDRESS_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    localparam int c_DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with word count, programmable almost-full /
//               almost-empty thresholds, selectable standard or FWFT read
//               mode and sticky overflow/underflow flags. All status outputs
//               are registered from the next-count value.
// Ports       : Clk             - clock, all logic on posedge
//               Clear_in        - synchronous active-high clear
//               Data_in         - write data
//               WriteEn_in      - write request
//               Full_out        - count == FIFO_DEPTH
//               AlmostFull_out  - count >= ALMOST_FULL_LVL
//               ReadEn_in       - read request (FWFT: pop head word)
//               Data_out        - read data
//               Empty_out       - no word available
//               AlmostEmpty_out - count <= ALMOST_EMPTY_LVL
//               WordCount_out   - stored words, 0..FIFO_DEPTH
//               Overflow_out    - sticky, write attempted while full
//               Underflow_out   - sticky, read attempted while empty
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int FIFO_DEPTH       = 1 << ADDRESS_WIDTH,
    parameter int FWFT             = FIFO_MODE_STD,
    parameter int ALMOST_FULL_LVL  = FIFO_DEPTH - 2,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic                                       Clk,
    input  logic                                       Clear_in,
    input  logic [DATA_WIDTH-1:0]                      Data_in,
    input  logic                                       WriteEn_in,
    output logic                                       Full_out,
    output logic                                       AlmostFull_out,
    input  logic                                       ReadEn_in,
    output logic [DATA_WIDTH-1:0]                      Data_out,
    output logic                                       Empty_out,
    output logic                                       AlmostEmpty_out,
    output logic [fifo_count_width(ADDRESS_WIDTH)-1:0] WordCount_out,
    output logic                                       Overflow_out,
    output logic                                       Underflow_out
);

    localparam int              c_CW    = fifo_count_width(ADDRESS_WIDTH);
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_AF    = c_CW'(ALMOST_FULL_LVL);
    localparam logic [c_CW-1:0] c_AE    = c_CW'(ALMOST_EMPTY_LVL);

    // ------------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------------
    if (ADDRESS_WIDTH < 2) begin : g_chk_aw
        $error("sync_fifo: ADDRESS_WIDTH must be >= 2");
    end
    if (FIFO_DEPTH != (1 << ADDRESS_WIDTH)) begin : g_chk_depth
        $error("sync_fifo: FIFO_DEPTH must equal 1 << ADDRESS_WIDTH");
    end
    if (ALMOST_FULL_LVL < 1 || ALMOST_FULL_LVL > FIFO_DEPTH) begin : g_chk_af
        $error("sync_fifo: ALMOST_FULL_LVL out of range 1..FIFO_DEPTH");
    end
    if (ALMOST_EMPTY_LVL < 0 || ALMOST_EMPTY_LVL > FIFO_DEPTH - 1) begin : g_chk_ae
        $error("sync_fifo: ALMOST_EMPTY_LVL out of range 0..FIFO_DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_chk_mode
        $error("sync_fifo: FWFT must be 0 or 1");
    end

    // ------------------------------------------------------------------------
    // Acceptance and count
    // ------------------------------------------------------------------------
    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
    logic [c_CW-1:0]          r_count;
    logic                     r_full;
    logic                     r_afull;
    logic                     r_empty;
    logic                     r_aempty;
    logic                     r_ovf;
    logic                     r_unf;

    logic                     w_wr_acc;
    logic                     w_rd_acc;
    logic [c_CW-1:0]          w_count_next;

    // RAM-side controls, driven by the mode-specific generate branch.
    logic                     w_ram_we;
    logic                     w_ram_re;
    logic                     w_ram_pop;
    logic [ADDRESS_WIDTH-1:0] w_ram_raddr;
    logic [ADDRESS_WIDTH-1:0] w_rd_ptr_next;
    logic [DATA_WIDTH-1:0]    w_ram_rdata;

    assign w_rd_acc = ReadEn_in & ~r_empty;
    // A simultaneous accepted read frees a slot, so a write is accepted
    // even when full.
    assign w_wr_acc = WriteEn_in & (~r_full | w_rd_acc);

    assign w_count_next  = r_count + c_CW'(w_wr_acc) - c_CW'(w_rd_acc);
    assign w_rd_ptr_next = r_rd_ptr + ADDRESS_WIDTH'(w_ram_pop);

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + ADDRESS_WIDTH'(w_ram_we);
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_full   <= (w_count_next == c_DEPTH);
            r_afull  <= (w_count_next >= c_AF);
            r_empty  <= (w_count_next == '0);
            r_aempty <= (w_count_next <= c_AE);
            if (WriteEn_in & r_full & ~w_rd_acc) begin
                r_ovf <= 1'b1;
            end
            if (ReadEn_in & r_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    sync_fifo_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clk     (Clk),
        .rst     (Clear_in),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (Data_in),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // The head word lives in r_out_data; the RAM holds the rest, so it
        // never holds more than FIFO_DEPTH-1 words and "RAM non-empty" is
        // simply a pointer inequality.
        logic                  r_out_valid;
        logic [DATA_WIDTH-1:0] r_out_data;
        logic                  r_byp_valid;
        logic [DATA_WIDTH-1:0] r_byp_data;
        logic                  w_ram_has;
        logic                  w_load;
        logic                  w_direct;
        logic [DATA_WIDTH-1:0] w_ram_head;

        assign w_ram_has = (r_wr_ptr != r_rd_ptr);
        assign w_load    = ~r_out_valid | w_rd_acc;
        assign w_ram_pop = w_load & w_ram_has;
        // With the RAM empty, a write that lands while the head slot is
        // being refilled goes straight into the output register.
        assign w_direct  = w_load & ~w_ram_has & w_wr_acc;
        assign w_ram_we  = w_wr_acc & ~w_direct;

        // The RAM continuously prefetches the word at the next read pointer,
        // so a pop can load the new head without a bubble.
        assign w_ram_re    = 1'b1;
        assign w_ram_raddr = w_rd_ptr_next;

        // A write into the address being prefetched in the same cycle is
        // missed by the read-first RAM; cover that one cycle from a copy.
        assign w_ram_head = r_byp_valid ? r_byp_data : w_ram_rdata;

        always_ff @(posedge Clk) begin
            if (Clear_in) begin
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
                r_byp_valid <= 1'b0;
                r_byp_data  <= '0;
            end else begin
                r_byp_valid <= w_ram_we & (r_wr_ptr == w_rd_ptr_next);
                r_byp_data  <= Data_in;
                if (w_load) begin
                    if (w_ram_pop) begin
                        r_out_data  <= w_ram_head;
                        r_out_valid <= 1'b1;
                    end else if (w_direct) begin
                        r_out_data  <= Data_in;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end
            end
        end

        assign Data_out = r_out_data;
    end else begin : g_std
        assign w_ram_we    = w_wr_acc;
        assign w_ram_pop   = w_rd_acc;
        assign w_ram_re    = w_rd_acc;
        assign w_ram_raddr = r_rd_ptr;
        assign Data_out    = w_ram_rdata;
    end

    assign Full_out        = r_full;
    assign AlmostFull_out  = r_afull;
    assign Empty_out       = r_empty;
    assign AlmostEmpty_out = r_aempty;
    assign WordCount_out   = r_count;
    assign Overflow_out    = r_ovf;
    assign Underflow_out   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Directed self-checking bench for sync_fifo. One instance in
//               standard mode and one in FWFT mode, both depth 16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;
    import fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-mode instance signals
    logic       s_clear, s_wen, s_ren;
    logic [7:0] s_din, s_dout;
    logic       s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
    logic [4:0] s_wc;

    // FWFT-mode instance signals
    logic       f_clear, f_wen, f_ren;
    logic [7:0] f_din, f_dout;
    logic       f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
    logic [4:0] f_wc;

    int checks   = 0;
    int failures = 0;

    logic [7:0] s_last_word;
    logic [7:0] f_last_word;

    sync_fifo #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (4),
        .FWFT          (FIFO_MODE_STD)
    ) u_std (
        .Clk             (clk),
        .Clear_in        (s_clear),
        .Data_in         (s_din),
        .WriteEn_in      (s_wen),
        .Full_out        (s_full),
        .AlmostFull_out  (s_af),
        .ReadEn_in       (s_ren),
        .Data_out        (s_dout),
        .Empty_out       (s_empty),
        .AlmostEmpty_out (s_ae),
        .WordCount_out   (s_wc),
        .Overflow_out    (s_ovf),
        .Underflow_out   (s_unf)
    );

    sync_fifo #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (4),
        .FWFT          (FIFO_MODE_FWFT)
    ) u_fwft (
        .Clk             (clk),
        .Clear_in        (f_clear),
        .Data_in         (f_din),
        .WriteEn_in      (f_wen),
        .Full_out        (f_full),
        .AlmostFull_out  (f_af),
        .ReadEn_in       (f_ren),
        .Data_out        (f_dout),
        .Empty_out       (f_empty),
        .AlmostEmpty_out (f_ae),
        .WordCount_out   (f_wc),
        .Overflow_out    (f_ovf),
        .Underflow_out   (f_unf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status vector order: {empty, almost_empty, full, almost_full, ovf, unf}
    task automatic test_reset();
        s_clear = 1'b1; s_wen = 1'b0; s_ren = 1'b0; s_din = 8'h00;
        f_clear = 1'b1; f_wen = 1'b0; f_ren = 1'b0; f_din = 8'h00;
        tick();
        tick();
        s_clear = 1'b0;
        f_clear = 1'b0;
        checks++;
        if ({s_empty, s_ae, s_full, s_af, s_ovf, s_unf} !== 6'b110000) begin
            failures++;
            $display("FAIL std_reset_status got=%b exp=110000", {s_empty, s_ae, s_full, s_af, s_ovf, s_unf});
        end
        checks++;
        if (s_wc !== 5'd0 || s_dout !== 8'h00) begin
            failures++;
            $display("FAIL std_reset_count_data got wc=%0d dout=%h exp wc=0 dout=00", s_wc, s_dout);
        end
        checks++;
        if ({f_empty, f_ae, f_full, f_af, f_ovf, f_unf} !== 6'b110000 || f_wc !== 5'd0 || f_dout !== 8'h00) begin
            failures++;
            $display("FAIL fwft_reset got status=%b wc=%0d dout=%h exp 110000 0 00",
                     {f_empty, f_ae, f_full, f_af, f_ovf, f_unf}, f_wc, f_dout);
        end
        tick();
        checks++;
        if ({s_empty, s_ae, s_full, s_af, s_ovf, s_unf} !== 6'b110000 || s_wc !== 5'd0) begin
            failures++;
            $display("FAIL std_idle_status got=%b wc=%0d exp=110000 wc=0", {s_empty, s_ae, s_full, s_af, s_ovf, s_unf}, s_wc);
        end
    endtask

    task automatic test_fill();
        logic [4:0] c;
        for (int i = 0; i < 16; i++) begin
            s_wen = 1'b1;
            s_din = 8'(i);
            tick();
            c = 5'(i + 1);
            checks++;
            if (s_wc !== c || s_ae !== (c <= 5'd2) || s_af !== (c >= 5'd14) ||
                s_full !== (c == 5'd16) || s_empty !== 1'b0 || s_ovf !== 1'b0) begin
                failures++;
                $display("FAIL fill_%0d got wc=%0d ae=%b af=%b full=%b empty=%b ovf=%b exp wc=%0d ae=%b af=%b full=%b empty=0 ovf=0",
                         i, s_wc, s_ae, s_af, s_full, s_empty, s_ovf, c, (c <= 5'd2), (c >= 5'd14), (c == 5'd16));
            end
        end
        s_din = 8'hFF;
        tick();
        s_wen = 1'b0;
        checks++;
        if (s_ovf !== 1'b1 || s_wc !== 5'd16 || s_full !== 1'b1) begin
            failures++;
            $display("FAIL overflow got ovf=%b wc=%0d full=%b exp ovf=1 wc=16 full=1", s_ovf, s_wc, s_full);
        end
        for (int i = 0; i < 16; i++) begin
            s_ren = 1'b1;
            tick();
            checks++;
            if (s_dout !== 8'(i) || s_wc !== 5'(15 - i)) begin
                failures++;
                $display("FAIL drain_%0d got dout=%h wc=%0d exp dout=%h wc=%0d", i, s_dout, s_wc, 8'(i), 15 - i);
            end
        end
        s_ren = 1'b0;
        checks++;
        if ({s_empty, s_ae, s_full, s_af, s_ovf, s_unf} !== 6'b110010) begin
            failures++;
            $display("FAIL drained_status got=%b exp=110010", {s_empty, s_ae, s_full, s_af, s_ovf, s_unf});
        end
    endtask

    task automatic test_back_to_back();
        int wv = 0;
        int rv = 0;
        for (int i = 0; i < 16; i++) begin
            s_wen = 1'b1; s_din = 8'(wv); wv++;
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            s_wen = 1'b1; s_ren = 1'b1; s_din = 8'(wv); wv++;
            tick();
            checks++;
            if (s_dout !== 8'(rv) || s_wc !== 5'd16 || s_full !== 1'b1) begin
                failures++;
                $display("FAIL b2b_full_%0d got dout=%h wc=%0d full=%b exp dout=%h wc=16 full=1", k, s_dout, s_wc, s_full, 8'(rv));
            end
            rv++;
        end
        s_wen = 1'b0;
        for (int k = 0; k < 11; k++) begin
            s_ren = 1'b1;
            tick();
            checks++;
            if (s_dout !== 8'(rv)) begin
                failures++;
                $display("FAIL b2b_drain_%0d got dout=%h exp dout=%h", k, s_dout, 8'(rv));
            end
            rv++;
        end
        checks++;
        if (s_wc !== 5'd5) begin
            failures++;
            $display("FAIL b2b_count5 got wc=%0d exp wc=5", s_wc);
        end
        for (int k = 0; k < 40; k++) begin
            s_wen = 1'b1; s_ren = 1'b1; s_din = 8'(wv); wv++;
            tick();
            checks++;
            if (s_dout !== 8'(rv) || s_wc !== 5'd5) begin
                failures++;
                $display("FAIL b2b_mid_%0d got dout=%h wc=%0d exp dout=%h wc=5", k, s_dout, s_wc, 8'(rv));
            end
            rv++;
        end
        s_wen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_ren = 1'b1;
            tick();
            checks++;
            if (s_dout !== 8'(rv)) begin
                failures++;
                $display("FAIL b2b_final_%0d got dout=%h exp dout=%h", k, s_dout, 8'(rv));
            end
            rv++;
        end
        s_ren = 1'b0;
        s_last_word = 8'(rv - 1);
        checks++;
        if (s_empty !== 1'b1 || s_wc !== 5'd0) begin
            failures++;
            $display("FAIL b2b_empty got empty=%b wc=%0d exp empty=1 wc=0", s_empty, s_wc);
        end
    endtask

    task automatic test_fwft_basic();
        f_wen = 1'b1; f_din = 8'hA5;
        tick();
        checks++;
        if (f_empty !== 1'b0 || f_dout !== 8'hA5 || f_wc !== 5'd1) begin
            failures++;
            $display("FAIL fwft_first got empty=%b dout=%h wc=%0d exp empty=0 dout=a5 wc=1", f_empty, f_dout, f_wc);
        end
        f_din = 8'h5A;
        tick();
        f_wen = 1'b0;
        checks++;
        if (f_dout !== 8'hA5 || f_wc !== 5'd2) begin
            failures++;
            $display("FAIL fwft_second got dout=%h wc=%0d exp dout=a5 wc=2", f_dout, f_wc);
        end
        f_ren = 1'b1;
        tick();
        checks++;
        if (f_dout !== 8'h5A || f_wc !== 5'd1 || f_empty !== 1'b0) begin
            failures++;
            $display("FAIL fwft_pop1 got dout=%h wc=%0d empty=%b exp dout=5a wc=1 empty=0", f_dout, f_wc, f_empty);
        end
        tick();
        f_ren = 1'b0;
        checks++;
        if (f_empty !== 1'b1 || f_wc !== 5'd0) begin
            failures++;
            $display("FAIL fwft_pop2 got empty=%b wc=%0d exp empty=1 wc=0", f_empty, f_wc);
        end
    endtask

    task automatic test_fwft_stream();
        int wv = 0;
        int rv = 0;
        for (int i = 0; i < 16; i++) begin
            f_wen = 1'b1; f_din = 8'(wv); wv++;
            tick();
        end
        f_wen = 1'b0;
        checks++;
        if (f_full !== 1'b1 || f_wc !== 5'd16 || f_dout !== 8'h00) begin
            failures++;
            $display("FAIL fwft_full got full=%b wc=%0d dout=%h exp full=1 wc=16 dout=00", f_full, f_wc, f_dout);
        end
        // Steady state at full, then at count 2 and count 1.
        for (int phase = 0; phase < 3; phase++) begin
            int level;
            int cycles;
            level  = (phase == 0) ? 16 : ((phase == 1) ? 2 : 1);
            cycles = (phase == 0) ? 20 : 6;
            while (wv - rv > level) begin
                f_ren = 1'b1;
                tick();
                rv++;
                checks++;
                if (f_dout !== 8'(rv) || f_wc !== 5'(wv - rv)) begin
                    failures++;
                    $display("FAIL fwft_drain_to_%0d got dout=%h wc=%0d exp dout=%h wc=%0d", level, f_dout, f_wc, 8'(rv), wv - rv);
                end
            end
            for (int k = 0; k < cycles; k++) begin
                f_wen = 1'b1; f_ren = 1'b1; f_din = 8'(wv); wv++;
                tick();
                rv++;
                checks++;
                if (f_dout !== 8'(rv) || f_wc !== 5'(level)) begin
                    failures++;
                    $display("FAIL fwft_b2b_l%0d_%0d got dout=%h wc=%0d exp dout=%h wc=%0d", level, k, f_dout, f_wc, 8'(rv), level);
                end
            end
            f_wen = 1'b0;
            f_ren = 1'b0;
        end
        f_ren = 1'b1;
        tick();
        f_ren = 1'b0;
        f_last_word = 8'(wv - 1);
        checks++;
        if (f_empty !== 1'b1 || f_wc !== 5'd0) begin
            failures++;
            $display("FAIL fwft_stream_empty got empty=%b wc=%0d exp empty=1 wc=0", f_empty, f_wc);
        end
    endtask

    task automatic test_underflow();
        s_ren = 1'b1;
        f_ren = 1'b1;
        tick();
        s_ren = 1'b0;
        f_ren = 1'b0;
        checks++;
        if (s_unf !== 1'b1 || s_dout !== s_last_word || s_wc !== 5'd0 || s_empty !== 1'b1) begin
            failures++;
            $display("FAIL std_underflow got unf=%b dout=%h wc=%0d empty=%b exp unf=1 dout=%h wc=0 empty=1",
                     s_unf, s_dout, s_wc, s_empty, s_last_word);
        end
        checks++;
        if (f_unf !== 1'b1 || f_dout !== f_last_word || f_wc !== 5'd0 || f_empty !== 1'b1) begin
            failures++;
            $display("FAIL fwft_underflow got unf=%b dout=%h wc=%0d empty=%b exp unf=1 dout=%h wc=0 empty=1",
                     f_unf, f_dout, f_wc, f_empty, f_last_word);
        end
        tick();
        tick();
        checks++;
        if (s_unf !== 1'b1 || f_unf !== 1'b1) begin
            failures++;
            $display("FAIL underflow_sticky got std=%b fwft=%b exp 1 1", s_unf, f_unf);
        end
        s_clear = 1'b1;
        f_clear = 1'b1;
        tick();
        s_clear = 1'b0;
        f_clear = 1'b0;
        checks++;
        if ({s_ovf, s_unf, f_ovf, f_unf} !== 4'b0000) begin
            failures++;
            $display("FAIL flags_cleared got std ovf/unf=%b%b fwft ovf/unf=%b%b exp 0000", s_ovf, s_unf, f_ovf, f_unf);
        end
    endtask

    task automatic test_clear_mid();
        for (int i = 0; i < 9; i++) begin
            s_wen = 1'b1; s_din = 8'(8'h40 + i);
            f_wen = 1'b1; f_din = 8'(8'h40 + i);
            tick();
        end
        checks++;
        if (s_wc !== 5'd9 || f_wc !== 5'd9) begin
            failures++;
            $display("FAIL clear_pre_count got std=%0d fwft=%0d exp 9 9", s_wc, f_wc);
        end
        s_clear = 1'b1; s_wen = 1'b1; s_ren = 1'b1; s_din = 8'h77;
        f_clear = 1'b1; f_wen = 1'b1; f_ren = 1'b1; f_din = 8'h77;
        tick();
        s_clear = 1'b0; s_wen = 1'b0; s_ren = 1'b0;
        f_clear = 1'b0; f_wen = 1'b0; f_ren = 1'b0;
        checks++;
        if ({s_empty, s_ae, s_full, s_af, s_ovf, s_unf} !== 6'b110000 || s_wc !== 5'd0 || s_dout !== 8'h00) begin
            failures++;
            $display("FAIL std_clear_mid got status=%b wc=%0d dout=%h exp 110000 0 00",
                     {s_empty, s_ae, s_full, s_af, s_ovf, s_unf}, s_wc, s_dout);
        end
        checks++;
        if ({f_empty, f_ae, f_full, f_af, f_ovf, f_unf} !== 6'b110000 || f_wc !== 5'd0 || f_dout !== 8'h00) begin
            failures++;
            $display("FAIL fwft_clear_mid got status=%b wc=%0d dout=%h exp 110000 0 00",
                     {f_empty, f_ae, f_full, f_af, f_ovf, f_unf}, f_wc, f_dout);
        end
        s_wen = 1'b1; s_din = 8'h33;
        f_wen = 1'b1; f_din = 8'h33;
        tick();
        s_wen = 1'b0;
        f_wen = 1'b0;
        checks++;
        if (f_dout !== 8'h33 || f_empty !== 1'b0 || f_wc !== 5'd1) begin
            failures++;
            $display("FAIL fwft_after_clear got dout=%h empty=%b wc=%0d exp dout=33 empty=0 wc=1", f_dout, f_empty, f_wc);
        end
        s_ren = 1'b1;
        tick();
        s_ren = 1'b0;
        checks++;
        if (s_dout !== 8'h33 || s_wc !== 5'd0) begin
            failures++;
            $display("FAIL std_after_clear got dout=%h wc=%0d exp dout=33 wc=0", s_dout, s_wc);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_fwft_basic();
        test_fwft_stream();
        test_underflow();
        test_clear_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
